// File: rtl/sync_mod_counter.sv
// Parameterised synchronous modulo counter: up/down, saturating load, one-shot, tc pulse.
// Optional registered Gray output when GRAY_OUT_EN is defined; otherwise q_gray is tied to 0.
module sync_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             one_shot,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done,
  output logic [WIDTH-1:0] q_gray
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] next_q;
  logic             next_tc;
  logic             next_done;
  logic             at_end;

  // The value the count would leave from when wrapping in the current direction.
  assign at_end = up ? (q == MAXV) : (q == '0);

  always_comb begin
    next_q    = q;
    next_tc   = 1'b0;
    next_done = done;
    if (load) begin
      next_q    = ({1'b0, load_val} > {1'b0, MAXV}) ? MAXV : load_val;
      next_done = 1'b0;
    end else if (en && !done) begin
      if (at_end) begin
        next_tc = 1'b1;
        if (one_shot) next_done = 1'b1;
        else          next_q    = up ? '0 : MAXV;
      end else begin
        next_q = up ? q + WIDTH'(1) : q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      q    <= RSTV;
      tc   <= 1'b0;
      done <= 1'b0;
    end else begin
      q    <= next_q;
      tc   <= next_tc;
      done <= next_done;
    end
  end

`ifdef GRAY_OUT_EN
  always_ff @(posedge clk) begin
    if (clear) q_gray <= RSTV ^ (RSTV >> 1);
    else       q_gray <= next_q ^ (next_q >> 1);
  end
`else
  assign q_gray = '0;
`endif

endmodule

// File: tb/tb_sync_mod_counter.sv
// Directed bench for sync_mod_counter (WIDTH=4, MODULUS=10) with a per-cycle arithmetic model
// and hand-computed literal checks along the test-plan sequence.
module tb_sync_mod_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         clear, en, up, load, one_shot;
  logic [W-1:0] load_val;
  logic [W-1:0] q, q_gray;
  logic         tc, done;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  int mq = 0;
  int mtc = 0;
  int mdone = 0;

  sync_mod_counter #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) dut (
    .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
    .one_shot(one_shot), .q(q), .tc(tc), .done(done), .q_gray(q_gray)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the counter as plain integer arithmetic mod M.
  always @(posedge clk) begin
    int nxt;
    if (clear) begin
      mq = 0; mtc = 0; mdone = 0;
    end else if (load) begin
      mq = (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
      mtc = 0; mdone = 0;
    end else if (en && mdone == 0) begin
      nxt = up ? mq + 1 : mq - 1;
      if (nxt < 0 || nxt >= M) begin
        mtc = 1;
        if (one_shot) mdone = 1;
        else          mq = (nxt + M) % M;
      end else begin
        mq = nxt; mtc = 0;
      end
    end else begin
      mtc = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_q", int'(q), mq);
      check("model_tc", int'(tc), mtc);
      check("model_done", int'(done), mdone);
`ifdef GRAY_OUT_EN
      check("model_gray", int'(q_gray), mq ^ (mq >> 1));
`else
      check("model_gray_off", int'(q_gray), 0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int eq, input int etc, input int edone);
    check({name, "_q"}, int'(q), eq);
    check({name, "_tc"}, int'(tc), etc);
    check({name, "_done"}, int'(done), edone);
  endtask

  initial begin
    clear = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd5; up = 1'b1; one_shot = 1'b0;
    step(); step();
    expect_out("reset", 0, 0, 0);
    check("reset_gray", int'(q_gray), 0);
    chk_on = 1'b1;

    // Free-run up across a full period.
    clear = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      expect_out("upwrap", i % 10, (i == 10) ? 1 : 0, 0);
`ifdef GRAY_OUT_EN
      if (i == 1) check("gray1", int'(q_gray), 1);
      if (i == 2) check("gray2", int'(q_gray), 3);
      if (i == 3) check("gray3", int'(q_gray), 2);
`else
      if (i <= 3) check("gray_off", int'(q_gray), 0);
`endif
    end

    // Down wrap.
    load = 1'b1; load_val = 4'd2; step();
    expect_out("load2", 2, 0, 0);
    load = 1'b0; up = 1'b0;
    step(); expect_out("down1", 1, 0, 0);
    step(); expect_out("down0", 0, 0, 0);
    step(); expect_out("down9", 9, 1, 0);
    step(); expect_out("down8", 8, 0, 0);

    // Hold with enable low.
    en = 1'b0; step(); expect_out("hold", 8, 0, 0);
    en = 1'b1;

    // Saturating load beats enable; then clear beats load.
    load = 1'b1; load_val = 4'd12; up = 1'b1; step();
    expect_out("loadsat", 9, 0, 0);
    clear = 1'b1; step();
    expect_out("clrload", 0, 0, 0);
    clear = 1'b0;

    // Load on a would-be wrap edge: load wins, no tc.
    load_val = 4'd9; step(); expect_out("load9", 9, 0, 0);
    load_val = 4'd4; step(); expect_out("loadwrap", 4, 0, 0);

    // One-shot up.
    load_val = 4'd7; step(); expect_out("load7", 7, 0, 0);
    load = 1'b0; one_shot = 1'b1; up = 1'b1;
    step(); expect_out("os8", 8, 0, 0);
    step(); expect_out("os9", 9, 0, 0);
    step(); expect_out("osterm", 9, 1, 1);
    step(); expect_out("osheld", 9, 0, 1);
    up = 1'b0; one_shot = 1'b0;
    step(); expect_out("osstick", 9, 0, 1);
    load = 1'b1; load_val = 4'd3; step();
    expect_out("osreload", 3, 0, 0);

    // One-shot down to 0.
    load = 1'b0; one_shot = 1'b1; up = 1'b0;
    step(); expect_out("osd2", 2, 0, 0);
    step(); expect_out("osd1", 1, 0, 0);
    step(); expect_out("osd0", 0, 0, 0);
    step(); expect_out("osdterm", 0, 1, 1);
    step(); expect_out("osdheld", 0, 0, 1);

    // Clear releases done.
    clear = 1'b1; step(); expect_out("clrdone", 0, 0, 0);
    clear = 1'b0; one_shot = 1'b0; up = 1'b1;
    step(); expect_out("resume", 1, 0, 0);

    @(posedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
